// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the LC-3 external memory responder.
// Holds the FSM state encoding, the access type and the byte-lane helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITS = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_t;

    localparam logic [15:0] READ_ZERO = 16'h0000;

    // Strobes are active-low; a low UB/LB enables the matching byte lane.
    function automatic logic [15:0] lane_mask(input logic ub, input logic lb);
        return {{8{~ub}}, {8{~lb}}};
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word-addressed storage split into two independent byte lanes.
// Each lane is its own inferred RAM with a registered read port.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    we,
    output logic [15:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] lane_rd_reg;

            // Contents are intentionally never reset.
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                lane_rd_reg <= lane_mem[addr];
            end

            assign rdata[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the LC-3 external bus: wait-state FSM, request latches
// and registered Ready/Data_out/Data_oe/Err handshake outputs.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    input  logic [15:0] Data_in,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    output logic        Ready,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [15:0] addr_reg;
    logic [15:0] data_reg;
    logic        ub_reg;
    logic        lb_reg;
    acc_t        acc_reg;
    logic        ready_reg;
    logic        oe_reg;
    logic        err_reg;
    logic [15:0] dout_reg;

    logic        req;
    logic [15:0] cur_addr;
    logic [15:0] cur_data;
    logic        cur_ub;
    logic        cur_lb;
    acc_t        cur_acc;
    logic        cur_hi_nz;
    logic        going_done;
    logic [1:0]  arr_we;
    logic [15:0] arr_rdata;

    assign req = !CE && (!WE || !OE);

    // With WAIT=0 the access completes on the sampling edge, before the
    // latches hold anything, so IDLE forwards the live bus instead.
    always_comb begin
        cur_addr = addr_reg;
        cur_data = data_reg;
        cur_ub   = ub_reg;
        cur_lb   = lb_reg;
        cur_acc  = acc_reg;
        if (state_reg == IDLE) begin
            cur_addr = ADDR;
            cur_data = Data_in;
            cur_ub   = UB;
            cur_lb   = LB;
            cur_acc  = !WE ? ACC_WRITE : ACC_READ;
        end
    end

    generate
        if (AW < 16) begin : g_range
            assign cur_hi_nz = |cur_addr[15:AW];
        end else begin : g_full
            assign cur_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        going_done = 1'b0;
        if (req) begin
            if (state_reg == IDLE && WAIT_CNT == 4'd0) begin
                going_done = 1'b1;
            end else if (state_reg == WAITS && cnt_reg == 4'd1) begin
                going_done = 1'b1;
            end
        end
    end

    assign arr_we = (going_done && cur_acc == ACC_WRITE && !cur_hi_nz)
                    ? {~cur_ub, ~cur_lb} : 2'b00;

    mem_resp_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (Clk),
        .addr  (cur_addr[AW-1:0]),
        .wdata (cur_data),
        .we    (arr_we),
        .rdata (arr_rdata)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 16'h0000;
            data_reg  <= 16'h0000;
            ub_reg    <= 1'b1;
            lb_reg    <= 1'b1;
            acc_reg   <= ACC_READ;
            ready_reg <= 1'b0;
            oe_reg    <= 1'b0;
            err_reg   <= 1'b0;
            dout_reg  <= READ_ZERO;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    oe_reg    <= 1'b0;
                    err_reg   <= 1'b0;
                    if (req) begin
                        addr_reg  <= ADDR;
                        data_reg  <= Data_in;
                        ub_reg    <= UB;
                        lb_reg    <= LB;
                        acc_reg   <= cur_acc;
                        cnt_reg   <= WAIT_CNT;
                        state_reg <= (WAIT_CNT == 4'd0) ? DONE : WAITS;
                    end
                end
                WAITS: begin
                    if (!req) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == 4'd1) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        ready_reg <= 1'b0;
                        oe_reg    <= 1'b0;
                        err_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (!ready_reg) begin
                        // First DONE cycle: the RAM read launched on entry is now valid.
                        ready_reg <= 1'b1;
                        err_reg   <= cur_hi_nz;
                        oe_reg    <= (acc_reg == ACC_READ);
                        if (acc_reg == ACC_READ) begin
                            dout_reg <= cur_hi_nz ? READ_ZERO
                                                  : (arr_rdata & lane_mask(ub_reg, lb_reg));
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Data_out = dout_reg;
    assign Data_oe  = oe_reg;
    assign Ready    = ready_reg;
    assign Err      = err_reg;

endmodule
